// File: rtl/alu_input_sequencer.sv
// Board front end for the 8-bit ALU: debounced buttons step an operand/opcode
// loading FSM, drive the ALU, and capture its result for display.

module alu_seq_debounce #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic          s1, s2, level, level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      pulse   <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_d <= level;
      pulse   <= level & ~level_d;
      // Level flips only after CYCLES consecutive disagreeing samples.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module alu_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int WIDTH           = 8,
  parameter int SEL_W           = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_next,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic [WIDTH-1:0] result_q,
  output logic             carry_q,
  output logic             result_valid,
  output logic [2:0]       phase
);
  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   next_pulse, clear_pulse;

  alu_seq_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst(rst), .raw(btn_next), .pulse(next_pulse)
  );

  alu_seq_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .rst(rst), .raw(btn_clear), .pulse(clear_pulse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD_A;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_A:  if (next_pulse) state_nxt = LOAD_B;
      LOAD_B:  if (next_pulse) state_nxt = LOAD_OP;
      LOAD_OP: if (next_pulse) state_nxt = EXEC;
      EXEC:    state_nxt = SHOW;
      SHOW:    if (next_pulse) state_nxt = LOAD_A;
      default: state_nxt = LOAD_A;
    endcase
    if (clear_pulse) state_nxt = LOAD_A;
  end

  // Only add/sub produce a meaningful carry; other opcodes report 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else if (clear_pulse) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      case (state)
        LOAD_A:  if (next_pulse) alu_a <= sw;
        LOAD_B:  if (next_pulse) alu_b <= sw;
        LOAD_OP: if (next_pulse) alu_sel <= sw[SEL_W-1:0];
        EXEC: begin
          result_q <= alu_result;
          carry_q  <= (alu_sel[SEL_W-1:1] == '0) ? alu_carry : 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result_valid = (state == SHOW);
  assign phase        = state;
endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer with a behavioural ALU and short debounce.

module tb_alu_input_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       btn_next, btn_clear;
  logic [7:0] alu_a, alu_b, alu_result, result_q;
  logic [2:0] alu_sel, phase;
  logic       alu_carry, carry_q, result_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_input_sequencer #(.DEBOUNCE_CYCLES(4), .WIDTH(8), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_clear(btn_clear),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .result_q(result_q), .carry_q(carry_q), .result_valid(result_valid), .phase(phase)
  );

  // Behavioural ALU; non-arithmetic ops deliberately drive carry high.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_sel)
      3'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: begin alu_result = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
      3'd2: begin alu_result = alu_a & alu_b; alu_carry = 1'b1; end
      3'd3: begin alu_result = alu_a | alu_b; alu_carry = 1'b1; end
      3'd4: begin alu_result = alu_a ^ alu_b; alu_carry = 1'b1; end
      default: begin alu_result = alu_a; alu_carry = 1'b1; end
    endcase
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] v);
    sw = v;
    btn_next = 1'b1;
    tick(10);
    btn_next = 1'b0;
    tick(10);
  endtask

  initial begin
    rst = 1'b1; sw = '0; btn_next = 1'b0; btn_clear = 1'b0;
    tick(3);
    check("rst_phase", {5'd0, phase}, 8'd0);
    check("rst_alu_a", alu_a, 8'd0);
    check("rst_valid", {7'd0, result_valid}, 8'd0);
    rst = 1'b0;
    tick(2);

    // 1: async reset mid-operation
    press(8'h12);
    press(8'h34);
    check("t1_phase_pre", {5'd0, phase}, 8'd2);
    check("t1_a_pre", alu_a, 8'h12);
    #2 rst = 1'b1;
    #1;
    check("t1_phase_rst", {5'd0, phase}, 8'd0);
    check("t1_a_rst", alu_a, 8'd0);
    check("t1_b_rst", alu_b, 8'd0);
    check("t1_res_rst", result_q, 8'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // 2: add with carry
    press(8'hC8); press(8'h64); press(8'h00);
    check("t2_phase", {5'd0, phase}, 8'd4);
    check("t2_result", result_q, 8'h2C);
    check("t2_carry", {7'd0, carry_q}, 8'd1);
    check("t2_valid", {7'd0, result_valid}, 8'd1);
    press(8'h00);
    check("t2_back", {5'd0, phase}, 8'd0);
    check("t2_hold", result_q, 8'h2C);
    check("t2_novalid", {7'd0, result_valid}, 8'd0);

    // 3: subtract with borrow
    press(8'h05); press(8'h0A); press(8'h01);
    check("t3_result", result_q, 8'hFB);
    check("t3_carry", {7'd0, carry_q}, 8'd1);
    press(8'h00);

    // 4: AND, carry suppressed
    press(8'hF0); press(8'h3C); press(8'h02);
    check("t4_sel", {5'd0, alu_sel}, 8'd2);
    check("t4_result", result_q, 8'h30);
    check("t4_carry", {7'd0, carry_q}, 8'd0);
    press(8'h00);
    check("t4_phase", {5'd0, phase}, 8'd0);

    // 5: short glitches must not advance; a clean press advances once
    sw = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      btn_next = 1'b1;
      tick(1 + (i % 3));
      btn_next = 1'b0;
      tick(4);
    end
    check("t5_glitch", {5'd0, phase}, 8'd0);
    btn_next = 1'b1;
    // pulse rises 7 edges after the raw rise; the FSM moves on the 8th
    tick(7);
    check("t5_before", {5'd0, phase}, 8'd0);
    tick(1);
    check("t5_after", {5'd0, phase}, 8'd1);
    check("t5_a", alu_a, 8'h5A);
    tick(12);
    btn_next = 1'b0;
    tick(12);
    check("t5_once", {5'd0, phase}, 8'd1);

    // 6: clear beats a simultaneous next
    press(8'h77);
    check("t6_pre", {5'd0, phase}, 8'd2);
    check("t6_b_pre", alu_b, 8'h77);
    btn_clear = 1'b1; btn_next = 1'b1;
    tick(12);
    check("t6_phase", {5'd0, phase}, 8'd0);
    check("t6_a", alu_a, 8'd0);
    check("t6_b", alu_b, 8'd0);
    check("t6_res", result_q, 8'd0);
    check("t6_carry", {7'd0, carry_q}, 8'd0);
    btn_clear = 1'b0; btn_next = 1'b0;
    tick(12);
    check("t6_noadv", {5'd0, phase}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
